dnasearch_axil_slave_regs: RTL and testbench
============================================

// Module: dnasearch_axil_slave_regs
// PURPOSE
//  AXI4-Lite responder (slave) for the DNASearch_SmallScale control/status register file.
//  It is the target of host/VIP-master AXI4-Lite single-beat writes and reads.
//  It holds NUM_REGS 32-bit registers and exports them, with per-register write strobes, to the search core.
//  Sits between the interconnect S00_AXI port and the search datapath.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  data bus width; only 32 is supported
//  C_S_AXI_ADDR_WIDTH  4   byte-address width; register index = addr[ADDR_WIDTH-1:2]
//  NUM_REGS            4   number of implemented registers, 1..2**(ADDR_WIDTH-2)
// PORTS
//  s00_axi_aclk      in   1      clock; all logic on the rising edge
//  s00_axi_aresetn   in   1      synchronous active-low reset
//  s00_axi_awaddr    in   AW     write address
//  s00_axi_awprot    in   3      ignored
//  s00_axi_awvalid   in   1      write-address valid
//  s00_axi_awready   out  1      write-address ready
//  s00_axi_wdata     in   32     write data
//  s00_axi_wstrb     in   4      byte enables
//  s00_axi_wvalid    in   1      write-data valid
//  s00_axi_wready    out  1      write-data ready
//  s00_axi_bresp     out  2      write response: OKAY=2'b00, SLVERR=2'b10
//  s00_axi_bvalid    out  1      write-response valid
//  s00_axi_bready    in   1      write-response ready
//  s00_axi_araddr    in   AW     read address
//  s00_axi_arprot    in   3      ignored
//  s00_axi_arvalid   in   1      read-address valid
//  s00_axi_arready   out  1      read-address ready
//  s00_axi_rdata     out  32     read data
//  s00_axi_rresp     out  2      read response: OKAY or SLVERR
//  s00_axi_rvalid    out  1      read-data valid
//  s00_axi_rready    in   1      read-data ready
//  reg_q             out  NUM_REGS*32  current register contents; reg i occupies bits [32i+31:32i]
//  reg_wr_pulse      out  NUM_REGS     one-cycle pulse on the cycle after register i commits a write
// BEHAVIOUR
//  Reset (aresetn=0 at a clock edge):
//   - all registers 0; all *ready, bvalid, rvalid and reg_wr_pulse 0; bresp, rresp and rdata 0.
//   - awready, wready and arready rise on the first edge with aresetn=1.
//  Reset mid-transaction: in-flight transactions are dropped with no response; register contents are cleared.
//  Write FSM, states W_IDLE -> W_RESP -> W_IDLE:
//   - AW and W are accepted independently and in either order. Each channel latches one beat.
//   - After its handshake, that channel's ready drops and stays low until the B handshake.
//   - When both address and data are held, the register commits on the next edge and bvalid rises on the same edge.
//     Minimum latency: 1 cycle from the later of the AW/W handshakes.
//   - Commit is byte-wise under wstrb. wstrb=0 leaves the register unchanged and still returns OKAY.
//   - bvalid and bresp hold until bready. awready and wready re-assert on the edge after the B handshake.
//     At most one write is outstanding.
//  Read FSM, states R_IDLE -> R_DATA -> R_IDLE:
//   - arready is high in R_IDLE. On the AR handshake, rdata and rresp are registered and rvalid rises on the next edge.
//   - rdata, rresp and rvalid hold stable until rready. arready re-asserts on the edge after the R handshake.
//  Address decode:
//   - addr[1:0] is ignored (unaligned accesses are treated as aligned).
//   - index >= NUM_REGS: the write is dropped with bresp=SLVERR; the read returns rdata=0 with rresp=SLVERR.
//  Collisions:
//   - Read and write are fully concurrent.
//   - A read whose AR handshake occurs on or before the commit edge of a write to the same register returns the pre-write value.
//  reg_q is registered, so it reflects a commit on the same edge that bvalid rises.
// STRUCTURE
//  - Package dnasearch_axil_pkg: resp_t enum (OKAY, SLVERR), wr_state_t and rd_state_t enums, REG_BYTES=4 constant.
//  - One sub-module, dnasearch_axil_regfile: strobed NUM_REGS x 32 storage with write port and combinational read port.
//    The write and read FSMs live in the top module.
// TESTING
//  1. Write 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC, then read them back.
//     -> bresp=OKAY every time; rdata 0x1..0x4 with rresp=OKAY; reg_q matches.
//  2. Write 0xAABBCCDD to 0x4, then 0x11223344 with wstrb=4'b0101.
//     -> read of 0x4 returns 0xAA22CC44.
//  3. Present W two cycles before AW, and hold bready low for 5 cycles.
//     -> wready drops after the W handshake; bvalid stays high and stable for 5 cycles; no second write is accepted.
//  4. With NUM_REGS=3, write 0xDEAD to 0xC, then read 0xC.
//     -> bresp=SLVERR; rresp=SLVERR with rdata=0; regs 0..2 are unchanged.
//  5. Issue AR to 0x8 on the same cycle as the AW/W handshake of 0x55 to 0x8 (old value 0x3).
//     -> rdata=0x3; a subsequent read returns 0x55.
//  6. Deassert aresetn for 1 cycle while bvalid=1 after a write of 0x7 to 0x0.
//     -> bvalid=0 and reg_q=0; after release, a read of 0x0 returns 0.

Source files
------------

// File: rtl/dnasearch_axil_pkg.sv
// Shared types and constants for the DNASearch AXI4-Lite register slave.
package dnasearch_axil_pkg;

    localparam int unsigned REG_BYTES = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/dnasearch_axil_regfile.sv
// NUM_REGS x 32-bit register storage: byte-strobed write port, combinational read port.
module dnasearch_axil_regfile
    import dnasearch_axil_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned IDX_W    = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [31:0]              wr_data,
    input  logic [REG_BYTES-1:0]     wr_strb,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [31:0]              rd_data,
    output logic [NUM_REGS*32-1:0]   q
);

    logic [31:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    for (int unsigned b = 0; b < REG_BYTES; b++) begin
                        if (wr_strb[b]) begin
                            mem[i][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = mem[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
        assign q[32*g +: 32] = mem[g];
    end

endmodule

// File: rtl/dnasearch_axil_slave_regs.sv
// AXI4-Lite slave for the DNASearch control/status registers; independent write and read FSMs.
module dnasearch_axil_slave_regs
    import dnasearch_axil_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned NUM_REGS           = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [NUM_REGS*32-1:0]            reg_q,
    output logic [NUM_REGS-1:0]               reg_wr_pulse
);

    localparam int unsigned IDX_W = C_S_AXI_ADDR_WIDTH - 2;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic                       aw_held, w_held;
    logic [IDX_W-1:0]           aw_idx, ar_idx;
    logic [31:0]                w_data, rf_rd_data;
    logic [REG_BYTES-1:0]       w_strb;
    logic                       aw_hs, w_hs, ar_hs;
    logic                       commit, b_done, wr_ok, rd_ok;
    resp_t                      b_resp, r_resp;
    logic                       unused_bits;

    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
    assign ar_idx = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

    assign s00_axi_bvalid = (wr_state == W_RESP);
    assign s00_axi_rvalid = (rd_state == R_DATA);
    assign s00_axi_bresp  = b_resp;
    assign s00_axi_rresp  = r_resp;

    always_comb begin
        aw_hs   = s00_axi_awvalid && s00_axi_awready;
        w_hs    = s00_axi_wvalid && s00_axi_wready;
        ar_hs   = s00_axi_arvalid && s00_axi_arready;
        wr_ok   = (32'(aw_idx) < NUM_REGS);
        rd_ok   = (32'(ar_idx) < NUM_REGS);
        wr_next = wr_state;
        rd_next = rd_state;
        commit  = 1'b0;
        b_done  = 1'b0;
        unique case (wr_state)
            W_IDLE: if (aw_held && w_held) begin
                commit  = 1'b1;
                wr_next = W_RESP;
            end
            W_RESP: if (s00_axi_bready) begin
                b_done  = 1'b1;
                wr_next = W_IDLE;
            end
        endcase
        unique case (rd_state)
            R_IDLE: if (ar_hs) rd_next = R_DATA;
            R_DATA: if (s00_axi_rready) rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    // Each channel's ready is the inverse of its held flag, so it stays low until the B handshake.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            aw_held         <= 1'b0;
            w_held          <= 1'b0;
            aw_idx          <= '0;
            w_data          <= '0;
            w_strb          <= '0;
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_arready <= 1'b0;
            b_resp          <= OKAY;
            r_resp          <= OKAY;
            s00_axi_rdata   <= '0;
            reg_wr_pulse    <= '0;
        end else begin
            if (aw_hs) aw_idx <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            if (w_hs) begin
                w_data <= s00_axi_wdata;
                w_strb <= s00_axi_wstrb;
            end
            aw_held         <= !b_done && (aw_held || aw_hs);
            w_held          <= !b_done && (w_held || w_hs);
            s00_axi_awready <= b_done || !(aw_held || aw_hs);
            s00_axi_wready  <= b_done || !(w_held || w_hs);
            s00_axi_arready <= (rd_next == R_IDLE);
            if (commit) b_resp <= wr_ok ? OKAY : SLVERR;
            if (ar_hs) begin
                s00_axi_rdata <= rd_ok ? rf_rd_data : '0;
                r_resp        <= rd_ok ? OKAY : SLVERR;
            end
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                reg_wr_pulse[i] <= commit && wr_ok && (aw_idx == IDX_W'(i));
            end
        end
    end

    dnasearch_axil_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk     (s00_axi_aclk),
        .rstn    (s00_axi_aresetn),
        .wr_en   (commit && wr_ok),
        .wr_idx  (aw_idx),
        .wr_data (w_data),
        .wr_strb (w_strb),
        .rd_idx  (ar_idx),
        .rd_data (rf_rd_data),
        .q       (reg_q)
    );

endmodule

// File: tb/tb_dnasearch_axil_slave_regs.sv
// Bench for dnasearch_axil_slave_regs: a 4-register and a 3-register instance share one driven bus.
module tb_dnasearch_axil_slave_regs;

    localparam logic [1:0] OK = 2'b00;
    localparam logic [1:0] SE = 2'b10;
    localparam int N0 = 4;
    localparam int N1 = 3;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        awready0, wready0, bvalid0, arready0, rvalid0;
    logic [1:0]  bresp0, rresp0;
    logic [31:0] rdata0;
    logic [127:0] reg_q0;
    logic [3:0]  pulse0;
    logic        awready1, wready1, bvalid1, arready1, rvalid1;
    logic [1:0]  bresp1, rresp1;
    logic [31:0] rdata1;
    logic [95:0] reg_q1;
    logic [2:0]  pulse1;

    int checks = 0;
    int errors = 0;
    logic [31:0] m0 [4];
    logic [31:0] m1 [4];

    always #5 clk = ~clk;

    dnasearch_axil_slave_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_REGS(N0)) dut0 (
        .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready0),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready0),
        .s00_axi_bresp(bresp0), .s00_axi_bvalid(bvalid0), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready0),
        .s00_axi_rdata(rdata0), .s00_axi_rresp(rresp0), .s00_axi_rvalid(rvalid0), .s00_axi_rready(rready),
        .reg_q(reg_q0), .reg_wr_pulse(pulse0));

    dnasearch_axil_slave_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_REGS(N1)) dut1 (
        .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready1),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready1),
        .s00_axi_bresp(bresp1), .s00_axi_bvalid(bvalid1), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready1),
        .s00_axi_rdata(rdata1), .s00_axi_rresp(rresp1), .s00_axi_rvalid(rvalid1), .s00_axi_rready(rready),
        .reg_q(reg_q1), .reg_wr_pulse(pulse1));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout", nm);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a[3:2]);
        if (idx < N0) m0[idx] = merge(m0[idx], d, s);
        if (idx < N1) m1[idx] = merge(m1[idx], d, s);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m0[i] = '0;
            m1[i] = '0;
        end
    endtask

    task automatic check_regq(input string nm);
        chk({nm, "_regq0"}, reg_q0, {m0[3], m0[2], m0[1], m0[0]});
        chk({nm, "_regq1"}, reg_q1, {m1[2], m1[1], m1[0]});
    endtask

    // lead > 0: W is presented lead cycles ahead of AW; lead < 0: AW ahead of W.
    task automatic do_write(input string nm, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input int hold, input logic [1:0] er0, input logic [1:0] er1);
        bit aw_done, w_done, hs_aw, hs_w;
        int cyc, idx;
        logic [3:0] p0;
        logic [2:0] p1;
        aw_done = 0; w_done = 0; cyc = 0;
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done)) begin
            awvalid = !aw_done && (cyc >= lead);
            wvalid  = !w_done && (cyc >= -lead);
            hs_aw = awvalid && awready0;
            hs_w  = wvalid && wready0;
            if (w_done)  chk({nm, "_wready_low"}, wready0, 0);
            if (aw_done) chk({nm, "_awready_low"}, awready0, 0);
            @(posedge clk); #1;
            aw_done = aw_done || hs_aw;
            w_done  = w_done || hs_w;
            cyc++;
            if (cyc > 40) begin
                tmo({nm, "_awhs"});
                break;
            end
        end
        awvalid = 0; wvalid = 0;
        chk({nm, "_b_early"}, bvalid0, 0);
        @(posedge clk); #1;
        chk({nm, "_b_lat"}, {bvalid0, bvalid1}, 2'b11);
        chk({nm, "_bresp0"}, bresp0, er0);
        chk({nm, "_bresp1"}, bresp1, er1);
        idx = int'(a[3:2]);
        p0 = (er0 == OK) ? (4'b0001 << idx) : 4'b0000;
        p1 = (er1 == OK) ? (3'b001 << idx) : 3'b000;
        chk({nm, "_pulse0"}, pulse0, p0);
        chk({nm, "_pulse1"}, pulse1, p1);
        model_write(a, d, s);
        check_regq(nm);
        repeat (hold) begin
            @(posedge clk); #1;
            chk({nm, "_bhold"}, {bvalid0, bresp0, awready0, wready0, pulse0}, {1'b1, er0, 2'b00, 4'b0000});
        end
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        chk({nm, "_b_done"}, {bvalid0, bvalid1, pulse0, pulse1}, '0);
    endtask

    task automatic do_read(input string nm, input logic [3:0] a, input int hold,
                           input logic [1:0] er0, input logic [31:0] ed0, input logic [1:0] er1, input logic [31:0] ed1);
        int n;
        araddr = a; arvalid = 1; n = 0;
        while (!arready0) begin
            @(posedge clk); #1;
            n++;
            if (n > 40) begin
                tmo({nm, "_arhs"});
                break;
            end
        end
        @(posedge clk); #1;
        arvalid = 0;
        chk({nm, "_rvalid"}, {rvalid0, rvalid1}, 2'b11);
        chk({nm, "_rd0"}, {rresp0, rdata0}, {er0, ed0});
        chk({nm, "_rd1"}, {rresp1, rdata1}, {er1, ed1});
        repeat (hold) begin
            @(posedge clk); #1;
            chk({nm, "_rhold"}, {rvalid0, rresp0, rdata0, arready0}, {1'b1, er0, ed0, 1'b0});
        end
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
        chk({nm, "_r_done"}, {rvalid0, rvalid1}, 2'b00);
    endtask

    typedef struct {
        bit          is_rd;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lead;
        int          hold;
        logic [1:0]  r0;
        logic [31:0] d0;
        logic [1:0]  r1;
        logic [31:0] d1;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{0, 4'h0, 32'h1,        4'hF,  0, 0, OK, 32'h0,        OK, 32'h0};
        tbl[1]  = '{0, 4'h4, 32'h2,        4'hF,  1, 0, OK, 32'h0,        OK, 32'h0};
        tbl[2]  = '{0, 4'h8, 32'h3,        4'hF, -1, 1, OK, 32'h0,        OK, 32'h0};
        tbl[3]  = '{0, 4'hC, 32'h4,        4'hF,  0, 0, OK, 32'h0,        SE, 32'h0};
        tbl[4]  = '{1, 4'h0, 32'h0,        4'h0,  0, 0, OK, 32'h1,        OK, 32'h1};
        tbl[5]  = '{1, 4'h4, 32'h0,        4'h0,  0, 2, OK, 32'h2,        OK, 32'h2};
        tbl[6]  = '{1, 4'h8, 32'h0,        4'h0,  0, 0, OK, 32'h3,        OK, 32'h3};
        tbl[7]  = '{1, 4'hC, 32'h0,        4'h0,  0, 1, OK, 32'h4,        SE, 32'h0};
        tbl[8]  = '{0, 4'h4, 32'hAABBCCDD, 4'hF,  0, 0, OK, 32'h0,        OK, 32'h0};
        tbl[9]  = '{0, 4'h4, 32'h11223344, 4'h5,  2, 5, OK, 32'h0,        OK, 32'h0};
        tbl[10] = '{1, 4'h4, 32'h0,        4'h0,  0, 0, OK, 32'hAA22CC44, OK, 32'hAA22CC44};
        tbl[11] = '{1, 4'h7, 32'h0,        4'h0,  0, 0, OK, 32'hAA22CC44, OK, 32'hAA22CC44};
        tbl[12] = '{0, 4'h8, 32'h0000FFFF, 4'h0, -2, 0, OK, 32'h0,        OK, 32'h0};
        tbl[13] = '{1, 4'hB, 32'h0,        4'h0,  0, 0, OK, 32'h3,        OK, 32'h3};
        tbl[14] = '{0, 4'hC, 32'h0000DEAD, 4'hF,  0, 0, OK, 32'h0,        SE, 32'h0};
        tbl[15] = '{1, 4'hC, 32'h0,        4'h0,  0, 0, OK, 32'h0000DEAD, SE, 32'h0};

        aresetn = 0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; wdata = '0; wstrb = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl0", {awready0, wready0, arready0, bvalid0, rvalid0, pulse0}, '0);
        chk("rst_ctl1", {awready1, wready1, arready1, bvalid1, rvalid1, pulse1}, '0);
        chk("rst_data", {bresp0, rresp0, rdata0, bresp1, rresp1, rdata1}, '0);
        check_regq("rst");
        aresetn = 1;
        @(posedge clk); #1;
        chk("rst_rel_rdy", {awready0, wready0, arready0, awready1, wready1, arready1}, 6'b111111);

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].is_rd)
                do_read($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].hold, tbl[i].r0, tbl[i].d0, tbl[i].r1, tbl[i].d1);
            else
                do_write($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].data, tbl[i].strb,
                         tbl[i].lead, tbl[i].hold, tbl[i].r0, tbl[i].r1);
        end

        // AR handshakes in the same cycle as AW/W to the same register: read sees the old value.
        chk("coll_rdy", {awready0, wready0, arready0}, 3'b111);
        awaddr = 4'h8; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 4'h8; arvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("coll_r0", {rvalid0, rresp0, rdata0, bvalid0}, {1'b1, OK, 32'h3, 1'b0});
        @(posedge clk); #1;
        chk("coll_b", {bvalid0, bresp0, bvalid1, bresp1}, {1'b1, OK, 1'b1, OK});
        chk("coll_r1", {rvalid0, rdata0, rvalid1, rdata1}, {1'b1, 32'h3, 1'b1, 32'h3});
        model_write(4'h8, 32'h55, 4'hF);
        check_regq("coll");
        bready = 1; rready = 1;
        @(posedge clk); #1;
        bready = 0; rready = 0;
        chk("coll_done", {bvalid0, rvalid0}, 2'b00);
        do_read("coll_rd", 4'h8, 0, OK, 32'h55, OK, 32'h55);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  a;
            logic [31:0] d;
            logic [3:0]  s;
            int idx, lead, hold;
            a = 4'($urandom_range(0, 15));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            lead = int'($urandom_range(0, 4)) - 2;
            hold = int'($urandom_range(0, 3));
            idx = int'(a[3:2]);
            if ($urandom_range(0, 1) == 0)
                do_write($sformatf("rnd%0d", i), a, d, s, lead, hold, OK, (idx < N1) ? OK : SE);
            else
                do_read($sformatf("rnd%0d", i), a, hold, OK, m0[idx],
                        (idx < N1) ? OK : SE, (idx < N1) ? m1[idx] : 32'h0);
        end

        // Reset while a write response is pending.
        awaddr = 4'h0; wdata = 32'h7; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        @(posedge clk); #1;
        chk("rstmid_b", {bvalid0, reg_q0[31:0]}, {1'b1, 32'h7});
        aresetn = 0;
        @(posedge clk); #1;
        model_clear();
        chk("rstmid_ctl", {bvalid0, bvalid1, awready0, wready0, arready0}, '0);
        check_regq("rstmid");
        aresetn = 1;
        @(posedge clk); #1;
        chk("rstmid_rel", {awready0, wready0, arready0}, 3'b111);
        do_read("rstmid_rd", 4'h0, 0, OK, 32'h0, OK, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
